vram_fetch_ctrl: RTL and testbench

Sequences the VRAM single read port between the display character engine and the host read path. Each granted display request is one cell fetch: a character byte from CHAR_BASE+index, then an attribute byte from ATTR_BASE+index. Host reads go in the gaps, with a fairness rule so neither requester starves. The block drives the VRAM read address and captures the VRAM's registered read data. Host writes go directly to the VRAM write port and do not pass through this block.

---
 rtl/vram_fetch_ctrl_if.sv | 27 ++
 rtl/vram_fetch_ctrl.sv | 91 +++++++++
 tb/tb_vram_fetch_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vram_fetch_ctrl_if.sv
// Request/response bundle between the display engine, the host read path,
// the VRAM read port and vram_fetch_ctrl.
interface vram_fetch_ctrl_if;
  logic        cellReq;
  logic [12:0] cellIdx;
  logic        cellReady;
  logic        cellValid;
  logic [7:0]  charData;
  logic [7:0]  attrData;
  logic        hostRdReq;
  logic [12:0] hostRdAddr;
  logic        hostRdAck;
  logic [7:0]  hostRdData;
  logic [12:0] vramRdAddr;
  logic [7:0]  vramRdData;

  // The master side is the requesters plus the VRAM; the controller is the slave.
  modport master (
    output cellReq, cellIdx, hostRdReq, hostRdAddr, vramRdData,
    input  cellReady, cellValid, charData, attrData, hostRdAck, hostRdData, vramRdAddr
  );

  modport slave (
    input  cellReq, cellIdx, hostRdReq, hostRdAddr, vramRdData,
    output cellReady, cellValid, charData, attrData, hostRdAck, hostRdData, vramRdAddr
  );
endinterface

// File: rtl/vram_fetch_ctrl.sv
// Arbitrates the VRAM display-side read port between cell fetches (char + attr
// byte) and single-byte host reads, alternating grants when both are pending.
module vram_fetch_ctrl #(
  parameter logic [12:0] CHAR_BASE = 13'h0000,
  parameter logic [12:0] ATTR_BASE = 13'h1000
) (
  input logic              clk,
  input logic              nrst,
  vram_fetch_ctrl_if.slave bus
);

  typedef enum logic [2:0] {IDLE, C1, C2, C3, H1, H2} state_t;
  typedef enum logic {GRANT_HOST, GRANT_DISP} grant_t;

  state_t      state, nextState;
  grant_t      lastGrant, nextLastGrant;
  logic [12:0] idxLatch;
  logic        hostWins;

  // Host takes the port if it is alone, or if display had the previous grant.
  assign hostWins = bus.hostRdReq && (!bus.cellReq || (lastGrant == GRANT_DISP));

  // cellReady also drops when the host is about to win, so cellReq & cellReady
  // is exactly the condition under which a display fetch starts.
  assign bus.cellReady = (state == IDLE) && !(bus.hostRdReq && (lastGrant == GRANT_DISP));

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= IDLE;
      lastGrant <= GRANT_HOST;
    end else begin
      state     <= nextState;
      lastGrant <= nextLastGrant;
    end
  end

  always_comb begin
    nextState     = state;
    nextLastGrant = lastGrant;
    unique case (state)
      IDLE: begin
        if (hostWins) begin
          nextState     = H1;
          nextLastGrant = GRANT_HOST;
        end else if (bus.cellReq) begin
          nextState     = C1;
          nextLastGrant = GRANT_DISP;
        end
      end
      C1:      nextState = C2;
      C2:      nextState = C3;
      C3:      nextState = IDLE;
      H1:      nextState = H2;
      H2:      nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Address issue and data capture; the VRAM returns data one cycle after the
  // address, so each capture happens one state after its address was issued.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      idxLatch       <= '0;
      bus.vramRdAddr <= '0;
      bus.charData   <= '0;
      bus.attrData   <= '0;
      bus.hostRdData <= '0;
      bus.cellValid  <= 1'b0;
      bus.hostRdAck  <= 1'b0;
    end else begin
      bus.cellValid <= (state == C3);
      bus.hostRdAck <= (state == H2);
      unique case (state)
        IDLE: begin
          if (nextState == C1) begin
            idxLatch       <= bus.cellIdx;
            bus.vramRdAddr <= CHAR_BASE + bus.cellIdx;
          end else if (nextState == H1) begin
            bus.vramRdAddr <= bus.hostRdAddr;
          end
        end
        C1:      bus.vramRdAddr <= ATTR_BASE + idxLatch;
        C2:      bus.charData   <= bus.vramRdData;
        C3:      bus.attrData   <= bus.vramRdData;
        H2:      bus.hostRdData <= bus.vramRdData;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vram_fetch_ctrl.sv
// Randomized scoreboard bench for vram_fetch_ctrl: drivers push expected
// responses from a VRAM image, a monitor pops and compares on cellValid/hostRdAck.
module tb_vram_fetch_ctrl;

  localparam logic [12:0] CHAR_BASE = 13'h0000;
  localparam logic [12:0] ATTR_BASE = 13'h1000;

  typedef struct {
    logic [7:0] charByte;
    logic [7:0] attrByte;
    int         dueCycle;
  } cellExp_t;

  typedef struct {
    logic [7:0] data;
    int         raiseCycle;
    int         cellsAtRaise;
  } hostExp_t;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic [7:0] mem [8192];
  int         cycleCount = 0;
  int         cellsDone = 0;
  int         checks = 0;
  int         failures = 0;
  cellExp_t   cellQ[$];
  hostExp_t   hostQ[$];
  cellExp_t   ce;
  hostExp_t   he;
  logic       prevValid = 1'b0;
  logic       prevAck = 1'b0;
  int         lat;

  vram_fetch_ctrl_if ifc ();

  vram_fetch_ctrl #(.CHAR_BASE(CHAR_BASE), .ATTR_BASE(ATTR_BASE)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (ifc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  // Behavioural VRAM with one cycle of read latency.
  always @(posedge clk) ifc.vramRdData <= mem[ifc.vramRdAddr];

  function automatic logic [12:0] wrapAdd(input int base, input int idx);
    int s;
    s = (base + idx) % 8192;
    return s[12:0];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, " cellReady"}, 32'(ifc.cellReady), 1);
    checkOutput({tag, " vramRdAddr"}, 32'(ifc.vramRdAddr), 0);
    checkOutput({tag, " charData"}, 32'(ifc.charData), 0);
    checkOutput({tag, " attrData"}, 32'(ifc.attrData), 0);
    checkOutput({tag, " hostRdData"}, 32'(ifc.hostRdData), 0);
    checkOutput({tag, " cellValid"}, 32'(ifc.cellValid), 0);
    checkOutput({tag, " hostRdAck"}, 32'(ifc.hostRdAck), 0);
  endtask

  // Display request: held until accepted; expected bytes come from the VRAM image.
  task automatic applyStimulusCell(input logic [12:0] idx, input bit expectOut,
                                   input bit chkAddr, output int acceptEdge);
    cellExp_t e;
    bit       ok;
    ok = 0;
    acceptEdge = -1;
    ifc.cellIdx = idx;
    ifc.cellReq = 1'b1;
    for (int t = 0; t < 40 && !ok; t++) begin
      @(negedge clk);
      if (ifc.cellReady) begin
        ok = 1;
        acceptEdge = cycleCount + 1;
        if (expectOut) begin
          e.charByte = mem[wrapAdd(CHAR_BASE, idx)];
          e.attrByte = mem[wrapAdd(ATTR_BASE, idx)];
          e.dueCycle = acceptEdge + 3;
          cellQ.push_back(e);
        end
      end
      @(posedge clk);
      #1;
    end
    ifc.cellReq = 1'b0;
    if (!ok) begin
      checks++;
      failures++;
      $display("[TB] FAIL cell accept timeout: got no accept expected accept within 40 cycles");
    end else if (chkAddr) begin
      checkOutput("char addr", 32'(ifc.vramRdAddr), 32'(wrapAdd(CHAR_BASE, idx)));
      tick(1);
      checkOutput("attr addr", 32'(ifc.vramRdAddr), 32'(wrapAdd(ATTR_BASE, idx)));
    end
  endtask

  task automatic waitAck(output int ackCycle);
    bit got;
    got = 0;
    ackCycle = -1;
    for (int t = 0; t < 40 && !got; t++) begin
      @(posedge clk);
      #1;
      if (ifc.hostRdAck) begin
        got = 1;
        ackCycle = cycleCount;
      end
    end
    if (!got) begin
      checks++;
      failures++;
      $display("[TB] FAIL host ack timeout: got no ack expected ack within 40 cycles");
    end
  endtask

  // Host read: level request, dropped on ack unless deliberately held one more cycle.
  task automatic applyStimulusHost(input logic [12:0] addr, input bit holdThroughAck, output int ackCycle);
    hostExp_t e;
    int       firstAck;
    ifc.hostRdAddr = addr;
    ifc.hostRdReq  = 1'b1;
    e.data         = mem[addr];
    e.raiseCycle   = cycleCount;
    e.cellsAtRaise = cellsDone;
    hostQ.push_back(e);
    waitAck(ackCycle);
    if (holdThroughAck) begin
      firstAck       = ackCycle;
      e.raiseCycle   = cycleCount;
      e.cellsAtRaise = cellsDone;
      hostQ.push_back(e);
      waitAck(ackCycle);
      checkOutput("held second ack spacing", 32'(ackCycle - firstAck), 3);
    end
    ifc.hostRdReq = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 100 && (cellQ.size() != 0 || hostQ.size() != 0); t++) tick(1);
    checkOutput("cell queue drained", 32'(cellQ.size()), 0);
    checkOutput("host queue drained", 32'(hostQ.size()), 0);
  endtask

  // Scoreboard monitor, sampling 1 time unit after each rising edge.
  always @(posedge clk) begin
    #1;
    if (nrst) begin
      if (ifc.cellValid) begin
        checkOutput("cellValid width", 32'(prevValid), 0);
        if (cellQ.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected cellValid: got 1 expected 0");
        end else begin
          ce = cellQ.pop_front();
          checkOutput("charData", 32'(ifc.charData), 32'(ce.charByte));
          checkOutput("attrData", 32'(ifc.attrData), 32'(ce.attrByte));
          checkOutput("cell latency", 32'(cycleCount), 32'(ce.dueCycle));
        end
        cellsDone++;
      end
      if (ifc.hostRdAck) begin
        checkOutput("hostRdAck width", 32'(prevAck), 0);
        if (hostQ.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected hostRdAck: got 1 expected 0");
        end else begin
          he = hostQ.pop_front();
          checkOutput("hostRdData", 32'(ifc.hostRdData), 32'(he.data));
          lat = cycleCount - he.raiseCycle;
          checks++;
          if (lat < 3 || lat > 7) begin
            failures++;
            $display("[TB] FAIL host latency: got %0d required 3..7", lat);
          end
          checks++;
          if (cellsDone - he.cellsAtRaise > 1) begin
            failures++;
            $display("[TB] FAIL host starvation: got %0d cells before ack required at most 1",
                     cellsDone - he.cellsAtRaise);
          end
        end
      end
    end
    prevValid = ifc.cellValid;
    prevAck   = ifc.hostRdAck;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int acc, prevAcc, ack, raise, accA, ackB;
    ifc.cellReq    = 1'b0;
    ifc.cellIdx    = '0;
    ifc.hostRdReq  = 1'b0;
    ifc.hostRdAddr = '0;
    for (int i = 0; i < 8192; i++) mem[i] = 8'($urandom);

    // Reset state, and no acceptance while reset is held.
    tick(2);
    checkResetValues("reset");
    ifc.cellIdx = 13'h0123;
    ifc.cellReq = 1'b1;
    tick(1);
    checkOutput("no accept in reset", 32'(ifc.vramRdAddr), 0);
    ifc.cellReq = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    tick(1);

    // Directed: idx 5 address sequence, lone host read, wrap-around, held host read.
    applyStimulusCell(13'h0005, 1, 1, acc);
    tick(4);
    raise = cycleCount;
    applyStimulusHost(13'h0ABC, 0, ack);
    checkOutput("host solo latency", 32'(ack - raise), 3);
    tick(1);
    applyStimulusCell(13'h1FFF, 1, 1, acc);
    tick(4);
    applyStimulusHost(13'(($urandom)), 1, ack);
    tick(2);

    // Display held continuously while the host keeps asking: grants must alternate.
    fork
      begin
        prevAcc = -1;
        for (int n = 0; n < 8; n++) begin
          applyStimulusCell(13'($urandom), 1, 0, acc);
          if (prevAcc >= 0) begin
            checks++;
            if (acc - prevAcc < 4 || acc - prevAcc > 7) begin
              failures++;
              $display("[TB] FAIL display spacing: got %0d required 4..7", acc - prevAcc);
            end
          end
          prevAcc = acc;
        end
      end
      begin
        int hAck;
        tick(2);
        for (int n = 0; n < 3; n++) begin
          applyStimulusHost(13'($urandom), 0, hAck);
          tick($urandom_range(0, 2));
        end
      end
    join
    drain();

    // Random mix of both requesters.
    for (int n = 0; n < 12; n++) begin
      fork
        begin
          int a;
          if ($urandom_range(0, 1) == 1) applyStimulusCell(13'($urandom), 1, 0, a);
        end
        begin
          int h;
          tick($urandom_range(0, 3));
          applyStimulusHost(13'($urandom), 0, h);
        end
      join
    end
    drain();

    // Reset during C2 aborts the fetch.
    applyStimulusCell(13'($urandom_range(1, 8191)), 0, 0, acc);
    tick(1);
    nrst = 1'b0;
    #1;
    checkResetValues("reset in C2");
    repeat (3) @(negedge clk);
    nrst = 1'b1;
    tick(8);

    // After reset lastGrant is host, so display wins a simultaneous request.
    raise = cycleCount;
    fork
      begin
        applyStimulusCell(13'($urandom), 1, 0, accA);
        checkOutput("display priority after reset", 32'(accA), 32'(raise + 1));
      end
      applyStimulusHost(13'($urandom), 0, ackB);
    join
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
